// File: rtl/key_remap_table_pkg.sv
// key_remap_table_pkg: shared constants, FSM encoding and one-hot helpers for the key remap table
package key_remap_table_pkg;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_KEY_W = 7;
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_RELEASE = 2'd1,
    WAIT_PRESS   = 2'd2,
    COMMIT       = 2'd3
  } state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic is_onehot(input logic [31:0] v);
    return $onehot(v);
  endfunction
  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) if (v[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/key_remap_table_if.sv
// key_remap_table_if: keypad-side and control-side signals of the key remap table
interface key_remap_table_if #(
  parameter int NUM_CH = key_remap_table_pkg::DEF_NUM_CH,
  parameter int KEY_W = key_remap_table_pkg::DEF_KEY_W
) ();
  localparam int CH_W = key_remap_table_pkg::idx_w(NUM_CH);
  localparam int SLOT_W = key_remap_table_pkg::idx_w(KEY_W);
  logic [NUM_CH*KEY_W-1:0] keys_in;
  logic [NUM_CH*KEY_W-1:0] keys_out;
  logic                    learn_req;
  logic [CH_W-1:0]         learn_ch;
  logic [SLOT_W-1:0]       learn_slot;
  logic                    learn_cancel;
  logic [NUM_CH-1:0]       restore_req;
  logic                    learn_busy;
  logic                    learn_done;
  logic                    learn_timeout;
  logic [SLOT_W-1:0]       learn_key;
  modport master (
    output keys_in, learn_req, learn_ch, learn_slot, learn_cancel, restore_req,
    input  keys_out, learn_busy, learn_done, learn_timeout, learn_key
  );
  modport slave (
    input  keys_in, learn_req, learn_ch, learn_slot, learn_cancel, restore_req,
    output keys_out, learn_busy, learn_done, learn_timeout, learn_key
  );
endinterface

// File: rtl/key_remap_bank.sv
// key_remap_bank: one channel's remap table with registered lookup; KEY_REMAP_SWAP_EN keeps the table a permutation on writes
module key_remap_bank import key_remap_table_pkg::*; #(
  parameter int KEY_W = DEF_KEY_W,
  localparam int SLOT_W = idx_w(KEY_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  keys_i,
  output logic [KEY_W-1:0]  keys_o,
  input  logic              wr_en_i,
  input  logic [SLOT_W-1:0] wr_phys_i,
  input  logic [SLOT_W-1:0] wr_slot_i,
  input  logic              restore_i
);
  logic [KEY_W-1:0] map_q [KEY_W];
  logic [KEY_W-1:0] keys_d, keys_q, slot_oh;
  assign slot_oh = KEY_W'(1) << wr_slot_i;
  assign keys_o = keys_q;
  // OR together the logical keys of every pressed physical key
  always_comb begin
    keys_d = '0;
    for (int i = 0; i < KEY_W; i++) keys_d = keys_d | (keys_i[i] ? map_q[i] : '0);
  end
`ifdef KEY_REMAP_SWAP_EN
  logic [SLOT_W-1:0] r;
  // find the physical key currently owning the target slot
  always_comb begin
    r = '0;
    for (int i = 0; i < KEY_W; i++) if (map_q[i] == slot_oh) r = SLOT_W'(i);
  end
`endif
  // table and lookup register; restore wins over a write, p's write lands last so r == p is a no-op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KEY_W; i++) map_q[i] <= KEY_W'(1) << i;
      keys_q <= '0;
    end else begin
      keys_q <= keys_d;
      if (restore_i) begin
        for (int i = 0; i < KEY_W; i++) map_q[i] <= KEY_W'(1) << i;
      end else if (wr_en_i) begin
`ifdef KEY_REMAP_SWAP_EN
        map_q[r] <= map_q[wr_phys_i];
`endif
        map_q[wr_phys_i] <= slot_oh;
      end
    end
  end
endmodule

// File: rtl/key_remap_table.sv
// key_remap_table: per-channel one-hot key remapping with a learn FSM; define KEY_REMAP_SWAP_EN for swap-on-learn
module key_remap_table import key_remap_table_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int KEY_W = DEF_KEY_W,
  parameter int TIMEOUT_CYC = 100000000
) (
  input logic clk,
  input logic rst,
  key_remap_table_if.slave bus
);
  localparam int CH_W = idx_w(NUM_CH);
  localparam int SLOT_W = idx_w(KEY_W);
  localparam int CNT_W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [SLOT_W-1:0] slot_q, slot_d, key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d, to_q, to_d;
  logic [KEY_W-1:0]  keys_ch;
  logic              abort, expired;
  assign keys_ch = bus.keys_in[ch_q*KEY_W +: KEY_W];
  assign abort = bus.learn_cancel || bus.restore_req[ch_q];
  assign expired = TIMEOUT_CYC != 0 && cnt_q == CNT_MAX && (state_q == WAIT_RELEASE || state_q == WAIT_PRESS);
  assign bus.learn_busy = state_q != IDLE;
  assign bus.learn_done = done_q;
  assign bus.learn_timeout = to_q;
  assign bus.learn_key = key_q;
  // learn sequencing; cancel/restore override everything, then timeout, then normal progress
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    slot_d = slot_q;
    key_d = key_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    to_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.learn_req && 32'(bus.learn_slot) < KEY_W && 32'(bus.learn_ch) < NUM_CH) begin
        state_d = WAIT_RELEASE;
        ch_d = bus.learn_ch;
        slot_d = bus.learn_slot;
        cnt_d = '0;
      end
      WAIT_RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = keys_ch == '0 ? WAIT_PRESS : WAIT_RELEASE;
      end
      WAIT_PRESS: begin
        cnt_d = cnt_q + 1'b1;
        if (is_onehot(32'(keys_ch))) begin
          state_d = COMMIT;
          key_d = SLOT_W'(onehot_to_idx(32'(keys_ch)));
        end
      end
      default: begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    endcase
    if (state_q != IDLE && (abort || expired)) begin
      state_d = IDLE;
      key_d = key_q;
      done_d = 1'b0;
      to_d = !abort;
    end
  end
  // FSM state, latched request and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      slot_q <= '0;
      key_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      slot_q <= slot_d;
      key_q <= key_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      to_q <= to_d;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
    key_remap_bank #(.KEY_W(KEY_W)) u_bank (
      .clk       (clk),
      .rst       (rst),
      .keys_i    (bus.keys_in[c*KEY_W +: KEY_W]),
      .keys_o    (bus.keys_out[c*KEY_W +: KEY_W]),
      .wr_en_i   (done_d && 32'(ch_q) == c),
      .wr_phys_i (key_q),
      .wr_slot_i (slot_q),
      .restore_i (bus.restore_req[c])
    );
  end
endmodule

// File: tb/tb_key_remap_table.sv
// tb_key_remap_table: scoreboard bench for key_remap_table (honours KEY_REMAP_SWAP_EN)
module tb_key_remap_table;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  key_remap_table_if #(.NUM_CH(2), .KEY_W(7)) bus ();
  key_remap_table #(.NUM_CH(2), .KEY_W(7), .TIMEOUT_CYC(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] mdl [2][7];
  logic [13:0] exp_q [$];
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [13:0] lookup(input logic [13:0] k);
    logic [13:0] r;
    r = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 7; i++)
        if (k[c*7+i]) r[c*7 +: 7] = r[c*7 +: 7] | mdl[c][i];
    return r;
  endfunction
  task automatic mdl_identity(input int c);
    for (int i = 0; i < 7; i++) mdl[c][i] = 7'(1) << i;
  endtask
  task automatic mdl_learn(input int c, input int p, input int s);
    logic [6:0] oh;
    oh = 7'(1) << s;
`ifdef KEY_REMAP_SWAP_EN
    for (int r = 0; r < 7; r++)
      if (mdl[c][r] == oh) begin
        mdl[c][r] = mdl[c][p];
        break;
      end
`endif
    mdl[c][p] = oh;
  endtask
  task automatic cyc(input string tag, input logic [13:0] k);
    bus.keys_in = k;
    exp_q.push_back(lookup(k));
    @(negedge clk);
    check_eq(tag, bus.keys_out, exp_q.pop_front());
  endtask
  task automatic pulses(input string tag, input logic busy, input logic done, input logic tmo);
    check_eq({tag, "_busy"}, bus.learn_busy, busy);
    check_eq({tag, "_done"}, bus.learn_done, done);
    check_eq({tag, "_timeout"}, bus.learn_timeout, tmo);
  endtask
  task automatic start_learn(input string tag, input logic ch, input logic [2:0] slot, input logic [13:0] k);
    bus.learn_req = 1'b1;
    bus.learn_ch = ch;
    bus.learn_slot = slot;
    cyc(tag, k);
    bus.learn_req = 1'b0;
  endtask
  initial begin
    bus.keys_in = '0;
    bus.learn_req = 1'b0;
    bus.learn_ch = '0;
    bus.learn_slot = '0;
    bus.learn_cancel = 1'b0;
    bus.restore_req = '0;
    mdl_identity(0);
    mdl_identity(1);
    @(negedge clk);
    check_eq("rst_keys_out", bus.keys_out, 0);
    check_eq("rst_learn_key", bus.learn_key, 0);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("id_ch0", 14'h0004);
    check_eq("id_ch0_const", bus.keys_out[6:0], 7'b0000100);
    cyc("id_ch1", 14'h2000);
    check_eq("id_ch1_const", bus.keys_out[13:7], 7'b1000000);
    cyc("id_all", 14'h3fff);
    start_learn("bad_slot", 1'b0, 3'd7, 14'h0);
    pulses("bad_slot", 1'b0, 1'b0, 1'b0);
    start_learn("l1_req", 1'b0, 3'd5, 14'h0);
    pulses("l1_armed", 1'b1, 1'b0, 1'b0);
    cyc("l1_rel", 14'h0);
    cyc("l1_press", 14'h1);
    pulses("l1_commit", 1'b1, 1'b0, 1'b0);
    cyc("l1_done_cyc", 14'h0);
    pulses("l1_done", 1'b0, 1'b1, 1'b0);
    check_eq("l1_key", bus.learn_key, 0);
    mdl_learn(0, 0, 5);
    cyc("l1_bit0", 14'h1);
    check_eq("l1_bit0_const", bus.keys_out[6:0], 7'b0100000);
    pulses("l1_idle", 1'b0, 1'b0, 1'b0);
    cyc("l1_bit5", 14'h20);
`ifdef KEY_REMAP_SWAP_EN
    check_eq("l1_bit5_const", bus.keys_out[6:0], 7'b0000001);
`else
    check_eq("l1_bit5_const", bus.keys_out[6:0], 7'b0100000);
`endif
    start_learn("l2_req", 1'b0, 3'd2, 14'h8);
    cyc("l2_held", 14'h8);
    cyc("l2_held2", 14'h18);
    pulses("l2_wait", 1'b1, 1'b0, 1'b0);
    cyc("l2_rel", 14'h0);
    cyc("l2_multi", 14'h18);
    pulses("l2_multi", 1'b1, 1'b0, 1'b0);
    cyc("l2_press", 14'h10);
    check_eq("l2_key", bus.learn_key, 4);
    pulses("l2_commit", 1'b1, 1'b0, 1'b0);
    cyc("l2_done_cyc", 14'h0);
    pulses("l2_done", 1'b0, 1'b1, 1'b0);
    mdl_learn(0, 4, 2);
    cyc("l2_bit4", 14'h10);
    check_eq("l2_bit4_const", bus.keys_out[6:0], 7'b0000100);
    start_learn("cn_req", 1'b0, 3'd6, 14'h0);
    cyc("cn_rel", 14'h0);
    bus.learn_cancel = 1'b1;
    cyc("cn_press", 14'h2);
    bus.learn_cancel = 1'b0;
    pulses("cn", 1'b0, 1'b0, 1'b0);
    check_eq("cn_key", bus.learn_key, 4);
    cyc("cn_after", 14'h2);
    check_eq("cn_after_const", bus.keys_out[6:0], 7'b0000010);
    pulses("cn_after", 1'b0, 1'b0, 1'b0);
    start_learn("to_req", 1'b1, 3'd0, 14'h0);
    for (int i = 1; i < 20; i++) begin
      cyc("to_wait", 14'h0);
      check_eq("to_early", bus.learn_timeout, 0);
    end
    check_eq("to_busy_before", bus.learn_busy, 1);
    cyc("to_fire_cyc", 14'h0);
    pulses("to_fire", 1'b0, 1'b0, 1'b1);
    cyc("to_after", 14'h80);
    check_eq("to_after_const", bus.keys_out[13:7], 7'b0000001);
    pulses("to_clear", 1'b0, 1'b0, 1'b0);
    start_learn("rs_req", 1'b1, 3'd3, 14'h0);
    cyc("rs_rel", 14'h0);
    pulses("rs_wait", 1'b1, 1'b0, 1'b0);
    bus.restore_req = 2'b11;
    cyc("rs_cyc", 14'h0);
    bus.restore_req = 2'b00;
    pulses("rs", 1'b0, 1'b0, 1'b0);
    mdl_identity(0);
    mdl_identity(1);
    cyc("rs_ch0", 14'h1);
    check_eq("rs_ch0_const", bus.keys_out[6:0], 7'b0000001);
    cyc("rs_all", 14'h3fff);
    pulses("rs_after", 1'b0, 1'b0, 1'b0);
    start_learn("ar_req", 1'b1, 3'd6, 14'h0);
    cyc("ar_rel", 14'h0);
    cyc("ar_press", 14'h200);
    pulses("ar_commit", 1'b1, 1'b0, 1'b0);
    check_eq("ar_key_pre", bus.learn_key, 2);
    #1 rst = 1'b1;
    #1;
    check_eq("ar_keys_out", bus.keys_out, 0);
    check_eq("ar_key", bus.learn_key, 0);
    pulses("ar_rst", 1'b0, 1'b0, 1'b0);
    bus.keys_in = '0;
    @(negedge clk);
    rst = 1'b0;
    mdl_identity(0);
    mdl_identity(1);
    cyc("ar_id", 14'h200);
    check_eq("ar_id_const", bus.keys_out[13:7], 7'b0000100);
    pulses("ar_after", 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/key_remap_table.md
Name: key_remap_table

Overview:
- Parametrised, clocked key-remapping table: per channel, a one-hot physical key vector maps to a one-hot logical key vector.
- Generalises the two fixed note/length remap memories to NUM_CH channels of KEY_W keys each.
- Adds an on-line "learn" FSM that captures the next physical key press and assigns it to a requested logical slot.
- Sits between the debounced keypad scanner and the game/playback logic.

Parameters:
- NUM_CH, 2, number of independent remap tables (channel 0 = note keys, channel 1 = length keys).
- KEY_W, 7, keys per channel; each table has KEY_W entries of KEY_W bits.
- TIMEOUT_CYC, 100000000, learn timeout in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- keys_in  in  NUM_CH*KEY_W  debounced physical keys; channel c occupies bits [c*KEY_W +: KEY_W].
- keys_out  out  NUM_CH*KEY_W  registered logical keys, same packing.
- learn_req  in  1  start-learn strobe (single cycle).
- learn_ch  in  clog2(NUM_CH)  channel to learn; sampled with learn_req.
- learn_slot  in  clog2(KEY_W)  logical slot index to assign; sampled with learn_req.
- learn_cancel  in  1  abort learn without change.
- restore_req  in  NUM_CH  per-channel synchronous reload of the identity map.
- learn_busy  out  1  FSM not in IDLE.
- learn_done  out  1  single-cycle pulse when a commit occurs.
- learn_timeout  out  1  single-cycle pulse when the timeout expires.
- learn_key  out  clog2(KEY_W)  index of the last captured physical key; holds its value until the next capture.

Behaviour:
- Reset:
  - Every table is identity: entry i = 1<<i.
  - FSM IDLE; timeout counter 0.
  - All outputs 0.
- Lookup:
  - keys_out[c] = OR of map[c][i] over all set bits i of keys_in[c].
  - Latency 1 cycle.
  - Uses table contents as they stand at the start of the cycle; a write becomes visible in the next cycle's lookup.
- FSM states: IDLE, WAIT_RELEASE, WAIT_PRESS, COMMIT.
  - IDLE: learn_req = 1 latches ch/slot, clears the timeout counter and goes to WAIT_RELEASE.
  - If learn_slot >= KEY_W, the request is ignored.
  - learn_req while busy is ignored.
  - WAIT_RELEASE: goes to WAIT_PRESS when keys_in[ch] == 0.
  - WAIT_PRESS: exactly one bit p set goes to COMMIT and latches p into learn_key.
  - WAIT_PRESS: zero or multiple bits set stays in WAIT_PRESS; multi-press is not a capture.
  - COMMIT (1 cycle): map[ch][p] <= 1<<slot, learn_done = 1, then go to IDLE.
- Timeout:
  - The counter increments in WAIT_RELEASE/WAIT_PRESS.
  - At TIMEOUT_CYC-1 the FSM goes to IDLE with learn_timeout = 1 and no table change.
- learn_cancel: in any non-IDLE state, go to IDLE next cycle with no change and no pulses. Cancel beats a same-cycle capture.
- restore_req[c]: sets table c to identity next cycle.
  - If c equals the active learn channel, the learn aborts to IDLE with no done pulse.
  - Restore beats COMMIT.
- Async rst mid-learn: immediate return to reset state, including tables.
- Outputs learn_done and learn_timeout are never high together.

Optional Feature:
- KEY_REMAP_SWAP_EN defined:
  - COMMIT keeps each table a permutation.
  - Let q = current logical index of p, and r = the physical key currently mapped to slot. Then map[r] <= 1<<q and map[p] <= 1<<slot, in the same cycle.
  - If r == p, nothing changes, but learn_done still pulses.
- Undefined: plain overwrite of map[p]; duplicate logical mappings are allowed.

Decomposition:
- Shared package/header holds:
  - default KEY_W / NUM_CH constants;
  - FSM state encoding (2-bit localparams);
  - a onehot_to_idx function;
  - an is_onehot function.
- One natural sub-module: key_remap_bank (a single channel's table, lookup register, write/swap/restore port), instantiated NUM_CH times by generate. The top level holds the shared FSM and timeout counter.

Test Plan:
- Reset, then keys_in ch0 = 7'b0000100 -> keys_out ch0 = 7'b0000100 one cycle later; ch1 also identity.
- learn ch0, slot 5, keys idle; then press keys_in ch0 = 7'b0000001 -> learn_done pulse, learn_key = 0.
  - Next press of bit 0 -> keys_out = 7'b0100000.
  - With SWAP_EN: bit 5 -> 7'b0000001.
- learn while ch0 bit 3 is held -> no capture until release.
  - A press of 7'b0011000 is ignored.
  - A later press of 7'b0010000 is captured, learn_key = 4.
- TIMEOUT_CYC = 20, learn with no press -> learn_timeout pulses exactly 20 cycles after entry; table unchanged; busy = 0.
- learn ch1; assert restore_req = 2'b10 while in WAIT_PRESS -> FSM IDLE, no done pulse, ch1 identity.
- Assert rst asynchronously during COMMIT -> keys_out = 0 immediately; identity after release; busy = 0.
